// File: rtl/izh_pkg.sv
// Shared constants for the izh spike logger: widths, frame length and serializer state encoding.
// Frame length depends on IZH_LOG_VPEAK_EN (adds the membrane potential to each event).
package izh_pkg;

    localparam int TS_W = 16;
    localparam int V_W  = 16;

`ifdef IZH_LOG_VPEAK_EN
    localparam int FRAME_BYTES = 4;
`else
    localparam int FRAME_BYTES = 2;
`endif

    localparam int ENTRY_W = 8 * FRAME_BYTES;

    typedef logic [ENTRY_W-1:0] entry_t;

    // Byte states are numbered consecutively so the serializer can step with +1.
    localparam int ST_W = 3;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_B0   = 3'd1;
    localparam logic [2:0] ST_B1   = 3'd2;
    localparam logic [2:0] ST_B2   = 3'd3;
    localparam logic [2:0] ST_B3   = 3'd4;

`ifdef IZH_LOG_VPEAK_EN
    localparam logic [2:0] ST_LAST = ST_B3;
`else
    localparam logic [2:0] ST_LAST = ST_B1;
`endif

endpackage

// File: rtl/izh_event_fifo.sv
// Single-clock event FIFO; a push while full is accepted when a pop happens on the same edge.
module izh_event_fifo
    import izh_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        level    = wr_ptr_q - rd_ptr_q;
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/izh_spike_logger.sv
// Timestamps rising edges of the izh spike output, buffers them and streams them out as byte frames.
// IZH_LOG_VPEAK_EN appends the membrane potential sampled at the event to each frame.
module izh_spike_logger
    import izh_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          spike,
    input  logic [V_W-1:0]                v,
    input  logic                          clr_ovf,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic [DROP_CNT_W-1:0]         drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    logic [TS_W-1:0]       ts_q, ts_d;
    logic                  spike_q;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [ST_W-1:0]       state_q, state_d;
    entry_t                frame_q, frame_d;

    logic   spike_evt;
    logic   drop;
    entry_t entry;
    entry_t fifo_rd_data;
    logic   fifo_pop;
    logic   fifo_full;
    logic   fifo_empty;

`ifdef IZH_LOG_VPEAK_EN
    assign entry = {ts_q, v};
`else
    assign entry = ts_q;
    logic unused_v;
    assign unused_v = ^v;
`endif

    // The entry carries ts_q as it was before the capturing edge.
    always_comb begin
        spike_evt = spike & ~spike_q & enable;
        drop      = spike_evt & fifo_full & ~fifo_pop;
        ts_d      = enable ? ts_q + 1'b1 : ts_q;
    end

    izh_event_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (spike_evt),
        .wr_data (entry),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // A drop in the same cycle as clr_ovf leaves one counted drop behind.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf) begin
                drop_cnt_d = {{(DROP_CNT_W-1){1'b0}}, 1'b1};
            end else if (!(&drop_cnt_q)) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    // Loading from IDLE and reloading after the last byte share one path for gapless frames.
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        fifo_pop = 1'b0;
        if ((state_q == ST_IDLE) || ((state_q == ST_LAST) && out_ready)) begin
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                frame_d  = fifo_rd_data;
                state_d  = ST_B0;
            end else begin
                state_d  = ST_IDLE;
            end
        end else if (out_ready) begin
            state_d = state_q + 1'b1;
        end
    end

    always_comb begin
        out_valid = (state_q != ST_IDLE);
        case (state_q)
            ST_B0:   out_data = frame_q[ENTRY_W-1 -: 8];
            ST_B1:   out_data = frame_q[ENTRY_W-9 -: 8];
`ifdef IZH_LOG_VPEAK_EN
            ST_B2:   out_data = frame_q[15:8];
            ST_B3:   out_data = frame_q[7:0];
`endif
            default: out_data = 8'h00;
        endcase
        overflow   = overflow_q;
        drop_count = drop_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q       <= '0;
            spike_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            state_q    <= ST_IDLE;
        end else begin
            ts_q       <= ts_d;
            spike_q    <= spike;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            state_q    <= state_d;
        end
    end

    // Frame contents are only visible through out_data, which reads zero in IDLE.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

endmodule

// File: tb/tb_izh_spike_logger.sv
// Scoreboard bench for izh_spike_logger: expected frame bytes are queued as events are driven
// and compared against every accepted output byte.
`timescale 1ns/1ps
module tb_izh_spike_logger;

    localparam int FIFO_DEPTH = 4;
    localparam int DROP_CNT_W = 8;
`ifdef IZH_LOG_VPEAK_EN
    localparam int FB = 4;
`else
    localparam int FB = 2;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic spike = 1'b0;
    logic clr_ovf = 1'b0;
    logic out_ready = 1'b0;
    logic [15:0] v = 16'h1234;
    logic [7:0] out_data;
    logic out_valid;
    logic overflow;
    logic [DROP_CNT_W-1:0] drop_count;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    logic [7:0] sb_q[$];
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    izh_spike_logger #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DROP_CNT_W (DROP_CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .spike      (spike),
        .v          (v),
        .clr_ovf    (clr_ovf),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    // One clock; any byte accepted at the coming edge is checked against the scoreboard.
    task automatic tick(input int n);
        logic [7:0] exp_b;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_unexpected_byte: got %02h, required no byte", out_data);
                end else begin
                    exp_b = sb_q.pop_front();
                    if (out_data !== exp_b)
                        $display("FAIL sb_byte: got %02h, required %02h", out_data, exp_b);
                    else
                        n_pass++;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_event(input logic [15:0] ts);
        sb_q.push_back(ts[15:8]);
        sb_q.push_back(ts[7:0]);
`ifdef IZH_LOG_VPEAK_EN
        sb_q.push_back(v[15:8]);
        sb_q.push_back(v[7:0]);
`endif
    endtask

    // After this returns the timestamp counter reads 0; each further tick adds one.
    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b1;
        spike = 1'b0;
        clr_ovf = 1'b0;
        out_ready = 1'b0;
        sb_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 8'h00) $display("FAIL rst_data: got %02h, required 00", out_data); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b, required 0", overflow); else n_pass++;
        n_checks++; if (drop_count !== '0) $display("FAIL rst_drop_count: got %0d, required 0", drop_count); else n_pass++;
        n_checks++; if (fifo_level !== '0) $display("FAIL rst_level: got %0d, required 0", fifo_level); else n_pass++;
    endtask

    task automatic test_single_spike();
        do_reset();
        out_ready = 1'b1;
        tick(10);
        spike = 1'b1;
        sb_q.push_back(8'h00);
        sb_q.push_back(8'h0A);
`ifdef IZH_LOG_VPEAK_EN
        sb_q.push_back(v[15:8]);
        sb_q.push_back(v[7:0]);
`endif
        tick(1);
        n_checks++; if (fifo_level !== 1) $display("FAIL single_level_after_push: got %0d, required 1", fifo_level); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_early: got %b, required 0", out_valid); else n_pass++;
        tick(1);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_latency: got %b, required 1", out_valid); else n_pass++;
        tick(1);
        spike = 1'b0;
        tick(12);
        n_checks++; if (sb_q.size() != 0) $display("FAIL single_missing_bytes: got %0d left, required 0", sb_q.size()); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL single_overflow: got %b, required 0", overflow); else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        tick(3);
        spike = 1'b1;
        expect_event(16'h0003);
        tick(1);
        spike = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) tick(1);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid_timeout: got %b, required 1", out_valid); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h00)
                $display("FAIL bp_hold: got valid %b data %02h, required valid 1 data 00", out_valid, out_data);
            else
                n_pass++;
            tick(1);
        end
        out_ready = 1'b1;
        tick(1);
        n_checks++; if (out_data !== 8'h03 || out_valid !== 1'b1) $display("FAIL bp_next_byte: got %02h, required 03", out_data); else n_pass++;
        tick(10);
        n_checks++; if (sb_q.size() != 0) $display("FAIL bp_missing_bytes: got %0d left, required 0", sb_q.size()); else n_pass++;
    endtask

    // With ready low the first event sits in the frame register, so FIFO_DEPTH+1 are kept.
    task automatic test_overflow();
        do_reset();
        tick(2);
        for (int i = 0; i < 7; i++) begin
            spike = 1'b1;
            if (i < FIFO_DEPTH + 1) expect_event(16'(2 + 2*i));
            tick(1);
            spike = 1'b0;
            tick(1);
        end
        tick(2);
        n_checks++; if (fifo_level !== FIFO_DEPTH) $display("FAIL ovf_level: got %0d, required %0d", fifo_level, FIFO_DEPTH); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b, required 1", overflow); else n_pass++;
        n_checks++; if (drop_count !== 2) $display("FAIL ovf_drop_count: got %0d, required 2", drop_count); else n_pass++;
        out_ready = 1'b1;
        tick(12 * FB);
        n_checks++; if (sb_q.size() != 0) $display("FAIL ovf_missing_bytes: got %0d left, required 0", sb_q.size()); else n_pass++;
        n_checks++; if (fifo_level !== 0) $display("FAIL ovf_drained_level: got %0d, required 0", fifo_level); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", overflow); else n_pass++;
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear_flag: got %b, required 0", overflow); else n_pass++;
        n_checks++; if (drop_count !== 0) $display("FAIL ovf_clear_count: got %0d, required 0", drop_count); else n_pass++;
    endtask

    task automatic test_clr_vs_drop();
        do_reset();
        tick(2);
        for (int i = 0; i < 7; i++) begin
            spike = 1'b1;
            clr_ovf = (i == 6);
            if (i < FIFO_DEPTH + 1) expect_event(16'(2 + 2*i));
            tick(1);
            spike = 1'b0;
            clr_ovf = 1'b0;
            tick(1);
        end
        n_checks++; if (overflow !== 1'b1) $display("FAIL clrdrop_flag: got %b, required 1", overflow); else n_pass++;
        n_checks++; if (drop_count !== 1) $display("FAIL clrdrop_count: got %0d, required 1", drop_count); else n_pass++;
        out_ready = 1'b1;
        tick(12 * FB);
        n_checks++; if (sb_q.size() != 0) $display("FAIL clrdrop_missing_bytes: got %0d left, required 0", sb_q.size()); else n_pass++;
    endtask

    task automatic test_saturate();
        do_reset();
        tick(2);
        for (int i = 0; i < FIFO_DEPTH + 1 + 260; i++) begin
            spike = 1'b1;
            if (i < FIFO_DEPTH + 1) expect_event(16'(2 + 2*i));
            tick(1);
            spike = 1'b0;
            tick(1);
        end
        n_checks++; if (drop_count !== {DROP_CNT_W{1'b1}}) $display("FAIL sat_count: got %0d, required %0d", drop_count, {DROP_CNT_W{1'b1}}); else n_pass++;
        out_ready = 1'b1;
        tick(12 * FB);
        n_checks++; if (sb_q.size() != 0) $display("FAIL sat_missing_bytes: got %0d left, required 0", sb_q.size()); else n_pass++;
    endtask

    // The second event needs spike low for a cycle; enable=0 holds ts at 0 meanwhile.
    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        tick(65535);
        spike = 1'b1;
        expect_event(16'hFFFF);
        tick(1);
        spike = 1'b0;
        enable = 1'b0;
        tick(1);
        spike = 1'b1;
        enable = 1'b1;
        expect_event(16'h0000);
        tick(1);
        spike = 1'b0;
        for (int k = 0; k < 2*FB - 1; k++) begin
            n_checks++;
            if (out_valid !== 1'b1) $display("FAIL wrap_gap: got valid %b at cycle %0d, required 1", out_valid, k); else n_pass++;
            tick(1);
        end
        tick(6);
        n_checks++; if (sb_q.size() != 0) $display("FAIL wrap_missing_bytes: got %0d left, required 0", sb_q.size()); else n_pass++;
    endtask

    task automatic test_enable();
        do_reset();
        out_ready = 1'b1;
        tick(5);
        enable = 1'b0;
        spike = 1'b1;
        tick(3);
        spike = 1'b0;
        tick(10);
        n_checks++; if (out_valid !== 1'b0 || fifo_level !== 0) $display("FAIL en_captured: got valid %b level %0d, required 0 0", out_valid, fifo_level); else n_pass++;
        spike = 1'b1;
        enable = 1'b1;
        expect_event(16'h0005);
        tick(1);
        spike = 1'b0;
        tick(10);
        n_checks++; if (sb_q.size() != 0) $display("FAIL en_missing_bytes: got %0d left, required 0", sb_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        tick(2);
        spike = 1'b1;
        expect_event(16'h0002);
        tick(1);
        spike = 1'b0;
        tick(1);
        spike = 1'b1;
        tick(1);
        spike = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) tick(1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        n_checks++; if (out_data !== 8'h02 || out_valid !== 1'b1) $display("FAIL rstmid_in_b1: got %02h, required 02", out_data); else n_pass++;
        n_checks++; if (fifo_level !== 1) $display("FAIL rstmid_level_before: got %0d, required 1", fifo_level); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b, required 0", out_valid); else n_pass++;
        n_checks++; if (fifo_level !== 0) $display("FAIL rstmid_level: got %0d, required 0", fifo_level); else n_pass++;
        n_checks++; if (out_data !== 8'h00) $display("FAIL rstmid_data: got %02h, required 00", out_data); else n_pass++;
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        tick(20);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_after_release: got %b, required 0", out_valid); else n_pass++;
    endtask

`ifdef IZH_LOG_VPEAK_EN
    task automatic test_vpeak();
        do_reset();
        out_ready = 1'b1;
        tick(32);
        v = 16'h0F00;
        spike = 1'b1;
        sb_q.push_back(8'h00);
        sb_q.push_back(8'h20);
        sb_q.push_back(8'h0F);
        sb_q.push_back(8'h00);
        tick(1);
        spike = 1'b0;
        v = 16'hAAAA;
        tick(10);
        n_checks++; if (sb_q.size() != 0) $display("FAIL vpeak_missing_bytes: got %0d left, required 0", sb_q.size()); else n_pass++;
        v = 16'h1234;
    endtask
`endif

    initial begin
        test_reset();
        test_single_spike();
        test_backpressure();
        test_overflow();
        test_clr_vs_drop();
        test_saturate();
        test_enable();
        test_reset_mid_frame();
`ifdef IZH_LOG_VPEAK_EN
        test_vpeak();
`endif
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
